// File: rtl/rtc_hms_counter_if.sv
// Control, load, alarm and time-output signals of the real-time clock counter.
// The master drives run/load/alarm controls; the slave (the counter) drives the time outputs.
interface rtc_hms_counter_if;
  logic       en;
  logic       load;
  logic [4:0] set_hour;
  logic [5:0] set_minute;
  logic [5:0] set_second;
  logic       set_pm;
  logic       alarm_arm;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_minute;
  logic       alarm_pm;

  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       pm;
  logic       sec_tick;
  logic       alarm;
  logic       load_err;

  modport master (
    output en, load, set_hour, set_minute, set_second, set_pm,
    output alarm_arm, alarm_hour, alarm_minute, alarm_pm,
    input  hour, minute, second, pm, sec_tick, alarm, load_err
  );

  modport slave (
    input  en, load, set_hour, set_minute, set_second, set_pm,
    input  alarm_arm, alarm_hour, alarm_minute, alarm_pm,
    output hour, minute, second, pm, sec_tick, alarm, load_err
  );
endinterface

// File: rtl/rtc_hms_counter.sv
// Real-time clock: divides clk_i down to a 1 Hz tick and keeps hh:mm:ss in 24-hour or
// 12-hour (AM/PM) mode, with run/pause, validated time load and an hh:mm alarm.
module rtc_hms_counter #(
  parameter int unsigned CLK_FREQ = 1_000_000,
  parameter bit          H24      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  rtc_hms_counter_if.slave bus
);

  localparam int unsigned     PreW    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PreW-1:0] PreMax  = PreW'(CLK_FREQ - 1);
  localparam logic [PreW-1:0] PreOne  = PreW'(1);
  localparam logic [4:0]      HourRst = H24 ? 5'd0 : 5'd12;

  logic [PreW-1:0] pre_q, pre_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            pm_q, pm_d;
  logic            tick_q, tick_d;
  logic            alarm_q, alarm_d;
  logic            err_q, err_d;

  logic            tick;
  logic            hour_ok;
  logic            load_valid;
  logic [4:0]      inc_hour;
  logic [5:0]      inc_min;
  logic [5:0]      inc_sec;
  logic            inc_pm;
  logic            alarm_hit;

  assign tick = bus.en && (pre_q == PreMax);

  always_comb begin
    if (H24) begin
      hour_ok = (bus.set_hour <= 5'd23);
    end else begin
      hour_ok = (bus.set_hour >= 5'd1) && (bus.set_hour <= 5'd12);
    end
    load_valid = hour_ok && (bus.set_minute <= 6'd59) && (bus.set_second <= 6'd59);
  end

  // Time one second ahead of the current time, full carry chain in one step.
  always_comb begin
    inc_sec  = sec_q + 6'd1;
    inc_min  = min_q;
    inc_hour = hour_q;
    inc_pm   = pm_q;
    if (sec_q == 6'd59) begin
      inc_sec = 6'd0;
      if (min_q == 6'd59) begin
        inc_min = 6'd0;
        if (H24) begin
          inc_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else if (hour_q == 5'd12) begin
          inc_hour = 5'd1;
        end else begin
          inc_hour = hour_q + 5'd1;
          // Meridiem flips on 11 -> 12, not on 12 -> 1.
          if (hour_q == 5'd11) begin
            inc_pm = ~pm_q;
          end
        end
      end else begin
        inc_min = min_q + 6'd1;
      end
    end
  end

  assign alarm_hit = bus.alarm_arm && (inc_sec == 6'd0) &&
                     (inc_min == bus.alarm_minute) && (inc_hour == bus.alarm_hour) &&
                     (H24 || (inc_pm == bus.alarm_pm));

  always_comb begin
    pre_d   = pre_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pm_d    = pm_q;
    tick_d  = 1'b0;
    alarm_d = 1'b0;
    err_d   = 1'b0;
    if (bus.load && load_valid) begin
      // A valid load wins over a coincident tick; the tick is dropped.
      pre_d  = '0;
      hour_d = bus.set_hour;
      min_d  = bus.set_minute;
      sec_d  = bus.set_second;
      pm_d   = H24 ? 1'b0 : bus.set_pm;
    end else begin
      err_d = bus.load;
      if (tick) begin
        pre_d   = '0;
        hour_d  = inc_hour;
        min_d   = inc_min;
        sec_d   = inc_sec;
        pm_d    = inc_pm;
        tick_d  = 1'b1;
        alarm_d = alarm_hit;
      end else if (bus.en) begin
        pre_d = pre_q + PreOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q   <= '0;
      hour_q  <= HourRst;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      pm_q    <= 1'b0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pm_q    <= pm_d;
      tick_q  <= tick_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
    end
  end

  assign bus.hour     = hour_q;
  assign bus.minute   = min_q;
  assign bus.second   = sec_q;
  assign bus.pm       = pm_q;
  assign bus.sec_tick = tick_q;
  assign bus.alarm    = alarm_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Directed bench for rtc_hms_counter with CLK_FREQ=4: one 24-hour and one 12-hour instance.
// Inputs are driven and outputs sampled on the falling edge.
module tb_rtc_hms_counter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  rtc_hms_counter_if b24 ();
  rtc_hms_counter_if b12 ();

  rtc_hms_counter #(.CLK_FREQ(4), .H24(1'b1)) u_dut24 (.clk_i(clk), .rst_i(rst), .bus(b24));
  rtc_hms_counter #(.CLK_FREQ(4), .H24(1'b0)) u_dut12 (.clk_i(clk), .rst_i(rst), .bus(b12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is12;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    bit         pm;
    bit         exp_err;
    logic [4:0] eh;
    logic [5:0] em;
    logic [5:0] es;
    bit         epm;
  } vec_t;

  vec_t vt[13];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  task automatic chk_t24(input string nm, input int h, input int m, input int s, input int tk);
    chk({nm, ".hour"}, b24.hour, h);
    chk({nm, ".min"}, b24.minute, m);
    chk({nm, ".sec"}, b24.second, s);
    chk({nm, ".tick"}, b24.sec_tick, tk);
  endtask

  task automatic chk_t12(input string nm, input int h, input int m, input int s, input int pm,
                         input int tk);
    chk({nm, ".hour"}, b12.hour, h);
    chk({nm, ".min"}, b12.minute, m);
    chk({nm, ".sec"}, b12.second, s);
    chk({nm, ".pm"}, b12.pm, pm);
    chk({nm, ".tick"}, b12.sec_tick, tk);
  endtask

  task automatic load24(input int h, input int m, input int s);
    b24.load       = 1'b1;
    b24.set_hour   = 5'(h);
    b24.set_minute = 6'(m);
    b24.set_second = 6'(s);
    b24.set_pm     = 1'b0;
  endtask

  task automatic load12(input int h, input int m, input int s, input int pm);
    b12.load       = 1'b1;
    b12.set_hour   = 5'(h);
    b12.set_minute = 6'(m);
    b12.set_second = 6'(s);
    b12.set_pm     = pm[0];
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    vt[0]  = '{0, 5'd12, 6'd34, 6'd56, 0, 0, 5'd12, 6'd34, 6'd56, 0};
    vt[1]  = '{0, 5'd24, 6'd0,  6'd0,  0, 1, 5'd12, 6'd34, 6'd56, 0};
    vt[2]  = '{0, 5'd23, 6'd59, 6'd59, 0, 0, 5'd23, 6'd59, 6'd59, 0};
    vt[3]  = '{0, 5'd0,  6'd60, 6'd0,  0, 1, 5'd23, 6'd59, 6'd59, 0};
    vt[4]  = '{0, 5'd0,  6'd0,  6'd60, 0, 1, 5'd23, 6'd59, 6'd59, 0};
    vt[5]  = '{0, 5'd0,  6'd0,  6'd0,  0, 0, 5'd0,  6'd0,  6'd0,  0};
    vt[6]  = '{0, 5'd31, 6'd63, 6'd63, 0, 1, 5'd0,  6'd0,  6'd0,  0};
    vt[7]  = '{0, 5'd5,  6'd6,  6'd7,  1, 0, 5'd5,  6'd6,  6'd7,  0};
    vt[8]  = '{1, 5'd0,  6'd10, 6'd0,  0, 1, 5'd12, 6'd0,  6'd2,  0};
    vt[9]  = '{1, 5'd12, 6'd59, 6'd59, 1, 0, 5'd12, 6'd59, 6'd59, 1};
    vt[10] = '{1, 5'd13, 6'd0,  6'd0,  0, 1, 5'd12, 6'd59, 6'd59, 1};
    vt[11] = '{1, 5'd1,  6'd0,  6'd0,  0, 0, 5'd1,  6'd0,  6'd0,  0};
    vt[12] = '{1, 5'd12, 6'd0,  6'd0,  1, 0, 5'd12, 6'd0,  6'd0,  1};

    rst = 1'b1;
    b24.en = 1'b1; b24.load = 1'b0; b24.set_hour = '0; b24.set_minute = '0;
    b24.set_second = '0; b24.set_pm = 1'b0; b24.alarm_arm = 1'b0; b24.alarm_hour = '0;
    b24.alarm_minute = '0; b24.alarm_pm = 1'b0;
    b12.en = 1'b1; b12.load = 1'b0; b12.set_hour = '0; b12.set_minute = '0;
    b12.set_second = '0; b12.set_pm = 1'b0; b12.alarm_arm = 1'b0; b12.alarm_hour = '0;
    b12.alarm_minute = '0; b12.alarm_pm = 1'b0;
    step(2);

    // Reset values
    chk_t24("rst24", 0, 0, 0, 0);
    chk("rst24.pm", b24.pm, 0);
    chk("rst24.alarm", b24.alarm, 0);
    chk("rst24.err", b24.load_err, 0);
    chk_t12("rst12", 12, 0, 0, 0, 0);

    // First two seconds after reset release: tick on edges 4 and 8 only
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk($sformatf("run24.e%0d.sec", i), b24.second, i / 4);
      chk($sformatf("run24.e%0d.tick", i), b24.sec_tick, (i % 4 == 0) ? 1 : 0);
      chk($sformatf("run12.e%0d.sec", i), b12.second, i / 4);
    end
    b24.en = 1'b0;
    b12.en = 1'b0;

    // Load validation table, counting paused
    for (int i = 0; i < 13; i++) begin
      if (vt[i].is12) begin
        load12(vt[i].h, vt[i].m, vt[i].s, vt[i].pm);
      end else begin
        b24.load = 1'b1; b24.set_hour = vt[i].h; b24.set_minute = vt[i].m;
        b24.set_second = vt[i].s; b24.set_pm = vt[i].pm;
      end
      step(1);
      b24.load = 1'b0;
      b12.load = 1'b0;
      if (vt[i].is12) begin
        chk($sformatf("vec%0d.err", i), b12.load_err, vt[i].exp_err);
        chk_t12($sformatf("vec%0d", i), vt[i].eh, vt[i].em, vt[i].es, vt[i].epm, 0);
        step(1);
        chk($sformatf("vec%0d.err_clr", i), b12.load_err, 0);
      end else begin
        chk($sformatf("vec%0d.err", i), b24.load_err, vt[i].exp_err);
        chk_t24($sformatf("vec%0d", i), vt[i].eh, vt[i].em, vt[i].es, 0);
        chk($sformatf("vec%0d.pm", i), b24.pm, vt[i].epm);
        step(1);
        chk($sformatf("vec%0d.err_clr", i), b24.load_err, 0);
      end
    end

    // 24-hour full wrap
    b24.en = 1'b1;
    load24(23, 59, 58);
    step(1);
    b24.load = 1'b0;
    step(3);
    chk_t24("wrap_pre", 23, 59, 58, 0);
    step(1);
    chk_t24("wrap_59", 23, 59, 59, 1);
    step(4);
    chk_t24("wrap_00", 0, 0, 0, 1);

    // 12-hour meridiem transitions
    b12.en = 1'b1;
    load12(11, 59, 59, 0);
    step(1);
    b12.load = 1'b0;
    step(4);
    chk_t12("am_to_pm", 12, 0, 0, 1, 1);
    load12(11, 59, 59, 1);
    step(1);
    b12.load = 1'b0;
    step(4);
    chk_t12("pm_to_am", 12, 0, 0, 0, 1);
    load12(12, 59, 59, 1);
    step(1);
    b12.load = 1'b0;
    step(4);
    chk_t12("h12_to_1", 1, 0, 0, 1, 1);
    b12.en = 1'b0;

    // Rejected load keeps time and prescaler phase
    load24(10, 0, 0);
    step(1);
    b24.load = 1'b0;
    step(2);
    b24.en = 1'b0;
    load24(24, 0, 0);
    step(1);
    b24.load = 1'b0;
    chk("bad_load.err", b24.load_err, 1);
    chk_t24("bad_keep", 10, 0, 0, 0);
    step(1);
    chk("bad_load.err_clr", b24.load_err, 0);
    b24.en = 1'b1;
    step(1);
    chk_t24("phase3", 10, 0, 0, 0);
    step(1);
    chk_t24("phase_tick", 10, 0, 1, 1);

    // Load coinciding with a tick: load wins, no tick
    load24(1, 2, 3);
    step(1);
    b24.load = 1'b0;
    step(3);
    load24(5, 5, 5);
    step(1);
    b24.load = 1'b0;
    chk_t24("load_wins", 5, 5, 5, 0);
    step(3);
    chk_t24("load_wins_wait", 5, 5, 5, 0);
    step(1);
    chk_t24("load_wins_next", 5, 5, 6, 1);

    // Armed alarm at 07:30
    b24.alarm_arm = 1'b1;
    b24.alarm_hour = 5'd7;
    b24.alarm_minute = 6'd30;
    load24(7, 29, 58);
    step(1);
    b24.load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk($sformatf("alarm.e%0d", i), b24.alarm, (i == 8) ? 1 : 0);
    end
    chk_t24("alarm_time", 7, 30, 0, 1);
    step(4);
    chk("alarm.after", b24.alarm, 0);

    // Disarmed: no pulse
    b24.alarm_arm = 1'b0;
    load24(7, 29, 58);
    step(1);
    b24.load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk($sformatf("disarmed.e%0d", i), b24.alarm, 0);
    end

    // Loaded straight onto the alarm time: no pulse
    b24.alarm_arm = 1'b1;
    load24(7, 30, 0);
    step(1);
    b24.load = 1'b0;
    chk("alarm_direct", b24.alarm, 0);
    chk_t24("alarm_direct_t", 7, 30, 0, 0);
    b24.alarm_arm = 1'b0;

    // 12-hour alarm must also match the meridiem
    b12.en = 1'b1;
    b12.alarm_arm = 1'b1;
    b12.alarm_hour = 5'd7;
    b12.alarm_minute = 6'd30;
    b12.alarm_pm = 1'b1;
    load12(7, 29, 59, 0);
    step(1);
    b12.load = 1'b0;
    step(4);
    chk("alarm12_am", b12.alarm, 0);
    chk_t12("alarm12_am_t", 7, 30, 0, 0, 1);
    load12(7, 29, 59, 1);
    step(1);
    b12.load = 1'b0;
    step(4);
    chk("alarm12_pm", b12.alarm, 1);
    b12.en = 1'b0;

    // Pause for 10 cycles mid-second
    load24(3, 0, 0);
    step(1);
    b24.load = 1'b0;
    step(2);
    b24.en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk($sformatf("pause.e%0d.tick", i), b24.sec_tick, 0);
    end
    chk_t24("pause_hold", 3, 0, 0, 0);
    b24.en = 1'b1;
    step(1);
    chk_t24("resume3", 3, 0, 0, 0);
    step(1);
    chk_t24("resume_tick", 3, 0, 1, 1);

    // Reset mid-count, overriding a valid load
    step(2);
    rst = 1'b1;
    load24(9, 9, 9);
    step(1);
    chk_t24("midrst24", 0, 0, 0, 0);
    chk("midrst24.alarm", b24.alarm, 0);
    chk("midrst24.err", b24.load_err, 0);
    chk_t12("midrst12", 12, 0, 0, 0, 0);
    rst = 1'b0;
    b24.load = 1'b0;
    step(3);
    chk_t24("postrst3", 0, 0, 0, 0);
    step(1);
    chk_t24("postrst4", 0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rtc_hms_counter.md
# rtc_hms_counter

Parametrised real-time clock counter: it divides the system clock into a 1 Hz tick and keeps seconds, minutes and hours, in either 24-hour or 12-hour (AM/PM) mode. It adds run/pause, a validated time load and an armed hh:mm alarm. It sits beside the UART demo logic as the time source for display and report formatting.

## Interface
Parameters:
- CLK_FREQ, 1_000_000, input clock cycles per second; must be ≥ 2; prescaler width = $clog2(CLK_FREQ)
- H24, 1, 1 = 24-hour mode (hours 0..23); 0 = 12-hour mode (hours 1..12 plus OutPm)

Ports:
- InClk  in  1  system clock; the block has one clock
- InRst  in  1  reset, synchronous, active-high
- InEn  in  1  1 = run; 0 = prescaler and time hold their values
- InLoad  in  1  single-cycle load strobe
- InSetHour  in  5  load value, hours
- InSetMinute  in  6  load value, minutes
- InSetSecond  in  6  load value, seconds
- InSetPm  in  1  load value, PM flag; ignored when H24=1
- InAlarmArm  in  1  1 = alarm enabled
- InAlarmHour  in  5  alarm hours, same encoding as the mode
- InAlarmMinute  in  6  alarm minutes
- InAlarmPm  in  1  alarm PM flag; ignored when H24=1
- OutHour  out  5  current hours
- OutMinute  out  6  current minutes
- OutSecond  out  6  current seconds
- OutPm  out  1  PM flag; constant 0 when H24=1
- OutSecTick  out  1  one-cycle pulse on every second increment
- OutAlarm  out  1  one-cycle alarm pulse
- OutLoadErr  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset values, all registered:
  - prescaler = 0
  - H24=1: time = 00:00:00
  - H24=0: time = 12:00:00 with OutPm=0
  - OutSecTick, OutAlarm, OutLoadErr = 0
- Prescaler:
  - Counts 0..CLK_FREQ-1 while InEn=1.
  - Tick condition: InEn=1 and prescaler == CLK_FREQ-1. The prescaler wraps to 0 on a tick.
  - Period is exactly CLK_FREQ enabled cycles.
- Tick cascade, all in the same cycle:
  - Second 59→0 carries into minute.
  - Minute 59→0 carries into hour.
  - H24=1: hour 23→0.
  - H24=0: hour sequence 12→1→…→11→12. OutPm toggles on the 11→12 transition (11:59:59 AM → 12:00:00 PM; 11:59:59 PM → 12:00:00 AM). 12:59:59 → 01:00:00 leaves OutPm unchanged.
- Load, sampled when InLoad=1:
  - Valid when second ≤ 59, minute ≤ 59, and hour ≤ 23 (H24=1) or hour in 1..12 (H24=0).
  - Valid load: time and OutPm take the load values and the prescaler clears to 0. This happens even when InEn=0.
  - Invalid load: the whole load is discarded, the time and prescaler are untouched, and OutLoadErr pulses.
  - Load has priority over a tick in the same cycle. The tick is lost and OutSecTick stays 0.
- Alarm:
  - OutAlarm pulses when a tick (not a load) moves the time to InAlarmHour:InAlarmMinute:00 while InAlarmArm=1.
  - In 12-hour mode, OutPm must also equal InAlarmPm.
  - The alarm inputs are compared against the next-state time.
- Pause: InEn=0 freezes everything except the load path. Time resumes from the same prescaler phase.
- Reset in the middle of a second returns all registers to reset values on the next edge. Reset overrides load.

## Timing
- Tick on edge N: the new time, OutSecTick=1 and any OutAlarm=1 are all visible after edge N, coherent in the same cycle.
- From reset release with InEn=1, OutSecond becomes 1 after exactly CLK_FREQ edges.
- After a valid load on edge L, the first increment is visible after edge L+CLK_FREQ (given InEn=1).
- OutLoadErr is visible after the edge that sampled the invalid load, for exactly 1 cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use CLK_FREQ=4.
- Reset, H24=1, InEn=1 → OutSecond=1 with OutSecTick=1 after the 4th edge; OutSecond=2 after the 8th edge; OutSecTick is high on 1 cycle in 4.
- H24=1, load 23:59:58 → 2 ticks later the time is 00:00:00, with OutMinute and OutHour wrapping in the same cycle as the second.
- H24=0:
  - load 11:59:59 PM=0 → next tick gives 12:00:00, OutPm=1
  - load 12:59:59 → next tick gives 01:00:00, OutPm unchanged
- Invalid load 24:00:00 (H24=1) or 00:10:00 (H24=0) → OutLoadErr is a single pulse and the prior time and prescaler phase are kept. Load coinciding with a tick → load values win and OutSecTick=0.
- Alarm armed at 07:30, load 07:29:58 → OutAlarm is a single pulse exactly when the time shows 07:30:00. No pulse if disarmed, or if the time is loaded directly to 07:30:00.
- InEn toggled 0 for 10 cycles mid-second → the time and prescaler hold; the tick arrives 10 cycles late. InRst asserted mid-count → reset values on the next edge.
